// File: rtl/lock_pkg.sv
// Shared constants for the keypad lock: entry FSM encoding, special key indices,
// digit capacity, and a one-hot-to-index helper.
package lock_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ENTRY = 2'd1;
   localparam logic [1:0] ST_SET   = 2'd2;
   localparam logic [1:0] ST_CLEAR = 2'd3;

   localparam logic [3:0] KEY_STAR   = 4'd10;
   localparam logic [3:0] KEY_HASH   = 4'd11;
   localparam logic [2:0] MAX_DIGITS = 3'd6;

   function automatic logic [3:0] onehot_index(input logic [11:0] k);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 0; i < 12; i++) begin
         if (k[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes the raw keypad, accepts one stable one-hot press, then waits for a stable release.
// Latency: 2 sync flops + DEBOUNCE_CYCLES stable samples + 1 output register; no backpressure.
module key_debouncer
   import lock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [11:0] key,
   output logic        press_valid,
   output logic [3:0]  key_index
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [11:0]   sync1_q, sync2_q, prev_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wait_rel_q, wait_rel_d;
   logic          press_valid_q, press_valid_d;
   logic [3:0]    key_index_q, key_index_d;
   logic          one_hot;
   logic [CW-1:0] run_len;

   assign one_hot = (sync2_q != 12'd0) && ((sync2_q & (sync2_q - 12'd1)) == 12'd0);

   always_comb begin
      cnt_d         = cnt_q;
      wait_rel_d    = wait_rel_q;
      press_valid_d = 1'b0;
      key_index_d   = key_index_q;
      run_len       = (sync2_q == prev_q) ? cnt_q + CW'(1) : CW'(1);
      if (wait_rel_q) begin
         // Any non-zero sample restarts the release run, so run_len is a clean zero count
         if (sync2_q != 12'd0) begin
            cnt_d = '0;
         end else if (run_len == CW'(DEBOUNCE_CYCLES)) begin
            cnt_d      = '0;
            wait_rel_d = 1'b0;
         end else begin
            cnt_d = run_len;
         end
      end else if (!one_hot) begin
         cnt_d = '0;
      end else if (run_len == CW'(DEBOUNCE_CYCLES)) begin
         cnt_d         = '0;
         wait_rel_d    = 1'b1;
         press_valid_d = 1'b1;
         key_index_d   = onehot_index(sync2_q);
      end else begin
         cnt_d = run_len;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         prev_q        <= '0;
         cnt_q         <= '0;
         wait_rel_q    <= 1'b0;
         press_valid_q <= 1'b0;
         key_index_q   <= '0;
      end else begin
         sync1_q       <= key;
         sync2_q       <= sync1_q;
         prev_q        <= sync2_q;
         cnt_q         <= cnt_d;
         wait_rel_q    <= wait_rel_d;
         press_valid_q <= press_valid_d;
         key_index_q   <= key_index_d;
      end
   end

   assign press_valid = press_valid_q;
   assign key_index   = key_index_q;

endmodule

// File: rtl/keypad_entry_controller.sv
// Keypad code-entry FSM: collects up to six digits, issues compare/commit/clear strobes.
// Latency: strobes one cycle after a debounced press; a press landing in CLEAR is held one cycle.
module keypad_entry_controller
   import lock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int MIN_DIGITS      = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [11:0] key,
   output logic [3:0]  data,
   output logic [5:0]  cs,
   output logic [2:0]  input_digit_count,
   output logic        compare,
   output logic        wr,
   output logic        clr,
   output logic        set_mode,
   output logic        err
);

   logic       press_valid;
   logic [3:0] key_index;

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk         (clk),
      .reset_n     (reset_n),
      .key         (key),
      .press_valid (press_valid),
      .key_index   (key_index)
   );

   logic [1:0] state_q, state_d;
   logic [2:0] count_q, count_d;
   logic [3:0] data_q, data_d;
   logic [5:0] cs_q, cs_d;
   logic       compare_q, compare_d, wr_q, wr_d, clr_q, clr_d, err_q, err_d;
   logic       set_mode_q, set_mode_d;
   logic       pend_q, pend_d;
   logic [3:0] pend_idx_q, pend_idx_d;
   logic       do_press;
   logic [3:0] idx;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      data_d     = data_q;
      cs_d       = 6'd0;
      compare_d  = 1'b0;
      wr_d       = 1'b0;
      clr_d      = 1'b0;
      err_d      = 1'b0;
      set_mode_d = set_mode_q;
      pend_d     = pend_q;
      pend_idx_d = pend_idx_q;
      do_press   = 1'b0;
      idx        = pend_idx_q;

      if (state_q == ST_CLEAR) begin
         clr_d   = 1'b1;
         count_d = 3'd0;
         state_d = set_mode_q ? ST_SET : ST_IDLE;
         if (press_valid) begin
            pend_d     = 1'b1;
            pend_idx_d = key_index;
         end
      end else begin
         if (pend_q) begin
            do_press = 1'b1;
            pend_d   = 1'b0;
         end else if (press_valid) begin
            do_press = 1'b1;
            idx      = key_index;
         end
      end

      if (do_press) begin
         if (idx == KEY_STAR) begin
            case (state_q)
               ST_ENTRY: begin
                  compare_d = 1'b1;
                  state_d   = ST_CLEAR;
               end
               ST_SET: begin
                  set_mode_d = 1'b0;
                  state_d    = ST_CLEAR;
               end
               default: err_d = 1'b1;
            endcase
         end else if (idx == KEY_HASH) begin
            if (state_q == ST_SET) begin
               if (32'(count_q) >= MIN_DIGITS) begin
                  wr_d       = 1'b1;
                  set_mode_d = 1'b0;
                  state_d    = ST_CLEAR;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               set_mode_d = 1'b1;
               state_d    = ST_CLEAR;
            end
         end else if (count_q == MAX_DIGITS) begin
            err_d = 1'b1;
         end else begin
            data_d  = idx;
            cs_d    = 6'(6'd1 << count_q);
            count_d = count_q + 3'd1;
            if (state_q == ST_IDLE) state_d = ST_ENTRY;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         data_q     <= '0;
         cs_q       <= '0;
         compare_q  <= 1'b0;
         wr_q       <= 1'b0;
         clr_q      <= 1'b0;
         err_q      <= 1'b0;
         set_mode_q <= 1'b0;
         pend_q     <= 1'b0;
         pend_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         data_q     <= data_d;
         cs_q       <= cs_d;
         compare_q  <= compare_d;
         wr_q       <= wr_d;
         clr_q      <= clr_d;
         err_q      <= err_d;
         set_mode_q <= set_mode_d;
         pend_q     <= pend_d;
         pend_idx_q <= pend_idx_d;
      end
   end

   assign data              = data_q;
   assign cs                = cs_q;
   assign input_digit_count = count_q;
   assign compare           = compare_q;
   assign wr                = wr_q;
   assign clr               = clr_q;
   assign err               = err_q;
   assign set_mode          = set_mode_q;

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Directed bench for keypad_entry_controller with DEBOUNCE_CYCLES = 16, MIN_DIGITS = 4.
module tb_keypad_entry_controller;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [11:0] key;
   logic [3:0]  data;
   logic [5:0]  cs;
   logic [2:0]  input_digit_count;
   logic        compare, wr, clr, set_mode, err;

   int n_comp = 0;
   int n_fail = 0;

   keypad_entry_controller #(.DEBOUNCE_CYCLES(16), .MIN_DIGITS(4)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .key               (key),
      .data              (data),
      .cs                (cs),
      .input_digit_count (input_digit_count),
      .compare           (compare),
      .wr                (wr),
      .clr               (clr),
      .set_mode          (set_mode),
      .err               (err)
   );

   always #5 clk = ~clk;

   // Strobe monitor, sampled on the falling edge
   int         cyc = 0, n_cs = 0, n_cmp = 0, n_wr = 0, n_clr = 0, n_err = 0, n_multi = 0;
   int         cmp_cyc = 0, clr_cyc = 0, wr_cyc = 0;
   logic [5:0] last_cs = '0;
   logic [3:0] last_data = '0;
   logic [2:0] cmp_cnt = '0, wr_cnt = '0, clr_cnt = '0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (($countones({|cs, compare, wr, clr, err}) > 1) || (cs != 6'd0 && $countones(cs) != 1))
         n_multi <= n_multi + 1;
      if (cs != 6'd0) begin
         n_cs <= n_cs + 1; last_cs <= cs; last_data <= data;
      end
      if (compare) begin n_cmp <= n_cmp + 1; cmp_cnt <= input_digit_count; cmp_cyc <= cyc; end
      if (wr)      begin n_wr  <= n_wr + 1;  wr_cnt  <= input_digit_count; wr_cyc  <= cyc; end
      if (clr)     begin n_clr <= n_clr + 1; clr_cnt <= input_digit_count; clr_cyc <= cyc; end
      if (err)       n_err <= n_err + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_comp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic hold_key(input logic [11:0] pat, input int hold, input int rel);
      @(negedge clk);
      key = pat;
      repeat (hold) @(negedge clk);
      key = 12'd0;
      repeat (rel) @(negedge clk);
   endtask

   task automatic press(input int idx);
      hold_key(12'(12'd1 << idx), 24, 24);
   endtask

   int b_cs, b_cmp, b_wr, b_clr, b_err;

   task automatic snap();
      b_cs = n_cs; b_cmp = n_cmp; b_wr = n_wr; b_clr = n_clr; b_err = n_err;
   endtask

   initial begin
      reset_n = 1'b0;
      key     = 12'd0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {16'd0, data, cs, input_digit_count, compare, wr, clr, err, set_mode}, 32'd0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // Short press must be ignored
      snap();
      hold_key(12'd1 << 3, 10, 30);
      check("short_press_cs", n_cs - b_cs, 0);
      check("short_press_count", input_digit_count, 0);

      // Digits 1..4 then '*'
      for (int d = 1; d <= 4; d++) begin
         press(d);
         check("entry_cs", last_cs, 32'(6'd1 << (d - 1)));
         check("entry_data", last_data, d);
         check("entry_count", input_digit_count, d);
      end
      snap();
      press(10);
      check("star_compare", n_cmp - b_cmp, 1);
      check("star_compare_count", cmp_cnt, 4);
      check("star_clr", n_clr - b_clr, 1);
      check("star_clr_next_cycle", clr_cyc - cmp_cyc, 1);
      check("star_clr_count", clr_cnt, 0);
      check("star_count_after", input_digit_count, 0);
      check("star_setmode", set_mode, 0);

      // '*' in IDLE is rejected
      snap();
      press(10);
      check("idle_star_err", n_err - b_err, 1);
      check("idle_star_cmp", n_cmp - b_cmp, 0);

      // Seven digits: sixth fills, seventh rejected
      snap();
      for (int d = 0; d < 7; d++) press(d);
      check("sat_cs_pulses", n_cs - b_cs, 6);
      check("sat_err", n_err - b_err, 1);
      check("sat_count", input_digit_count, 6);
      check("sat_data_held", data, 5);
      check("sat_last_cs", last_cs, 32'h20);
      snap();
      press(10);
      check("sat_compare_count", cmp_cnt, 6);
      check("sat_clr", n_clr - b_clr, 1);

      // Password set flow
      snap();
      press(11);
      check("set_enter_mode", set_mode, 1);
      check("set_enter_clr", n_clr - b_clr, 1);
      check("set_enter_count", input_digit_count, 0);
      press(5); press(6); press(7);
      snap();
      press(11);
      check("set_short_err", n_err - b_err, 1);
      check("set_short_wr", n_wr - b_wr, 0);
      check("set_short_mode", set_mode, 1);
      check("set_short_count", input_digit_count, 3);
      press(8);
      check("set_digit4_count", input_digit_count, 4);
      snap();
      press(11);
      check("set_commit_wr", n_wr - b_wr, 1);
      check("set_commit_count", wr_cnt, 4);
      check("set_commit_clr_next", clr_cyc - wr_cyc, 1);
      check("set_commit_mode", set_mode, 0);
      check("set_commit_count_after", input_digit_count, 0);

      // '*' during set abandons without strobe
      snap();
      press(11);
      press(1);
      press(10);
      check("set_abandon_mode", set_mode, 0);
      check("set_abandon_cmp", n_cmp - b_cmp, 0);
      check("set_abandon_clr", n_clr - b_clr, 2);
      check("set_abandon_count", input_digit_count, 0);

      // Two keys together
      snap();
      hold_key((12'd1 << 2) | (12'd1 << 5), 40, 30);
      check("multihot_strobes", (n_cs - b_cs) + (n_err - b_err) + (n_clr - b_clr), 0);
      check("multihot_count", input_digit_count, 0);

      // Held key gives one press
      snap();
      hold_key(12'd1 << 9, 200, 30);
      check("held_cs_once", n_cs - b_cs, 1);
      check("held_data", data, 9);
      check("held_count", input_digit_count, 1);

      // Reset mid-entry
      press(2);
      check("pre_reset_count", input_digit_count, 2);
      snap();
      reset_n = 1'b0;
      #1;
      check("async_reset_outputs", {16'd0, data, cs, input_digit_count, compare, wr, clr, err, set_mode}, 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      check("reset_no_clr", n_clr - b_clr, 0);
      check("reset_count", input_digit_count, 0);
      press(7);
      check("post_reset_cs", last_cs, 32'h01);
      check("post_reset_data", data, 7);

      check("strobe_exclusive", n_multi, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_entry_controller.md
KEYPAD_ENTRY_CONTROLLER -- requirements
Module: keypad_entry_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable clk samples required to accept a press or a release.
REQ-002 Parameter MIN_DIGITS, default 4: fewest digits accepted as a new password.
REQ-003 Ports (clock and reset first); one clock; reset is asynchronous and active-low:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- key  in  12  raw keypad lines, active-high: bit 0-9 = digits, bit 10 = '*', bit 11 = '#'
- data  out  4  BCD of the last accepted digit
- cs  out  6  one-hot digit-slot write strobe
- input_digit_count  out  3  digits held in the current entry, 0..6
- compare  out  1  one-cycle strobe, '*' with at least one digit
- wr  out  1  one-cycle password-commit strobe
- clr  out  1  one-cycle input-buffer clear strobe
- set_mode  out  1  level, high while a new password is being entered
- err  out  1  one-cycle rejected-key strobe

Function
REQ-004 key SHALL pass through a 2-flop synchronizer before any use.
REQ-005 A press SHALL be accepted only when the synchronized key is exactly one-hot and unchanged for DEBOUNCE_CYCLES consecutive cycles; zero or multi-hot patterns SHALL reset the debounce counter.
REQ-006 After an accepted press, no further press SHALL be accepted until key reads all-zero for DEBOUNCE_CYCLES consecutive cycles; holding a key SHALL produce exactly one press.
REQ-007 All strobes SHALL be registered and SHALL assert in the cycle after acceptance (latency 1); at most one of cs/compare/wr/clr/err SHALL be active in any cycle.
REQ-008 Entry FSM states: IDLE, ENTRY, SET, CLEAR; reset state is IDLE.
REQ-009 Digit in IDLE/ENTRY/SET with count < 6: drive data = BCD value, pulse cs[count], increment count; IDLE goes to ENTRY.
REQ-010 Digit with count = 6: pulse err; data, cs and count are unchanged.
REQ-011 data SHALL hold its value until the next accepted digit.
REQ-012 '*' in ENTRY: pulse compare with count unchanged, then go to CLEAR.
REQ-013 '*' in IDLE: pulse err.
REQ-014 '*' in SET: abandon the set; go to CLEAR with set_mode dropped.
REQ-015 '#' in IDLE/ENTRY: set_mode = 1, go to CLEAR.
REQ-016 '#' in SET with count >= MIN_DIGITS: pulse wr with count still valid, then go to CLEAR with set_mode = 0.
REQ-017 '#' in SET with count < MIN_DIGITS: pulse err and remain in SET.
REQ-018 CLEAR lasts exactly one cycle: pulse clr, count = 0; next state is SET if set_mode = 1, else IDLE.
REQ-019 A press accepted while in CLEAR SHALL be deferred one cycle, not dropped.
REQ-020 count SHALL saturate at 6 and never wrap.

Reset
REQ-021 On reset_n low, asynchronously: state = IDLE; data = 0; cs = 0; count = 0; compare, wr, clr, err, set_mode = 0; synchronizer and debounce counters cleared; release-wait flag cleared.
REQ-022 Reset mid-entry SHALL discard the partial entry without pulsing clr.
REQ-023 Deassertion of reset_n SHALL take effect on the next clk edge.

Structure
REQ-024 The FSM state encoding, key index constants (KEY_STAR = 10, KEY_HASH = 11) and MAX_DIGITS = 6 SHALL live in a shared package lock_pkg.
REQ-025 Debounce and the one-hot check SHALL be one sub-module, key_debouncer, outputting a one-cycle press_valid and a 4-bit key_index.

Verification
REQ-026 Key 3 held for 10 cycles, then released (DEBOUNCE_CYCLES = 16) -> no cs, count stays 0.
REQ-027 Digits 1, 2, 3, 4, then '*' -> cs 000001, 000010, 000100, 001000 with data 1, 2, 3, 4; compare pulse with count = 4; next cycle clr, count = 0.
REQ-028 Seven digits -> six cs pulses, the 7th press gives err, count = 6.
REQ-029 '#', digits 5, 6, 7, '#' -> err, state stays SET; add digit 8 and '#' -> wr with count = 4, then clr, set_mode = 0.
REQ-030 Keys 2 and 5 pressed together for 40 cycles -> no strobe.
REQ-031 Digit 9 held continuously -> exactly one cs pulse.
REQ-032 reset_n pulsed low after 2 digits -> all outputs 0 immediately, no clr pulse.
